// File: rtl/fb_scanout.sv
// Raster scanout for a 1-bit framebuffer.
// Generates the display timing and issues one framebuffer read per active pixel.
// Pixel data and sync/de are aligned so that every display output for a
// position appears two ce edges after that position's read address.
module fb_scanout #(
    parameter int   HOR_ACTIVE_PIXELS = 640,
    parameter int   VER_ACTIVE_PIXELS = 480,
    parameter int   HOR_FRONT_PORCH   = 16,
    parameter int   HOR_SYNC          = 96,
    parameter int   HOR_BACK_PORCH    = 48,
    parameter int   VER_FRONT_PORCH   = 10,
    parameter int   VER_SYNC          = 2,
    parameter int   VER_BACK_PORCH    = 33,
    parameter logic SYNC_ACTIVE_LEVEL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    output logic        rd_en,
    output logic [20:0] rd_addr,
    input  logic        rd_data,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        video_out,
    output logic        vblank,
    output logic        frame_start
);

    localparam int H_TOTAL = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC + HOR_BACK_PORCH;
    localparam int V_TOTAL = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC + VER_BACK_PORCH;

    // 11-bit versions of the region boundaries so comparisons stay width-matched
    localparam logic [10:0] H_ACTIVE     = 11'(HOR_ACTIVE_PIXELS);
    localparam logic [10:0] V_ACTIVE     = 11'(VER_ACTIVE_PIXELS);
    localparam logic [10:0] H_SYNC_FIRST = 11'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH);
    localparam logic [10:0] H_SYNC_LAST  = 11'(HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC - 1);
    localparam logic [10:0] V_SYNC_FIRST = 11'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH);
    localparam logic [10:0] V_SYNC_LAST  = 11'(VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC - 1);
    localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);

    localparam logic SYNC_IDLE = ~SYNC_ACTIVE_LEVEL;

    logic [10:0] h_cnt_reg, h_cnt_next;
    logic [10:0] v_cnt_reg, v_cnt_next;
    logic [20:0] addr_cnt_reg, addr_cnt_next;
    logic        line_end, frame_end, active;
    logic        hs_now, vs_now;

    // stage A carries the sync/de for the position whose address is on rd_addr;
    // stage B waits out the framebuffer read latency
    logic de_a_reg, hs_a_reg, vs_a_reg;
    logic de_b_reg, hs_b_reg, vs_b_reg;

    // Next-position, running-address and sync-level decode for the current position
    always_comb begin
        line_end      = (h_cnt_reg == H_LAST);
        frame_end     = line_end && (v_cnt_reg == V_LAST);
        active        = (h_cnt_reg < H_ACTIVE) && (v_cnt_reg < V_ACTIVE);
        h_cnt_next    = line_end ? 11'd0 : h_cnt_reg + 11'd1;
        v_cnt_next    = v_cnt_reg;
        if (line_end) begin
            v_cnt_next = (v_cnt_reg == V_LAST) ? 11'd0 : v_cnt_reg + 11'd1;
        end
        // blanking never increments, so consecutive lines get consecutive addresses
        addr_cnt_next = addr_cnt_reg;
        if (frame_end) begin
            addr_cnt_next = 21'd0;
        end else if (active) begin
            addr_cnt_next = addr_cnt_reg + 21'd1;
        end
        hs_now = ((h_cnt_reg >= H_SYNC_FIRST) && (h_cnt_reg <= H_SYNC_LAST)) ? SYNC_ACTIVE_LEVEL : SYNC_IDLE;
        vs_now = ((v_cnt_reg >= V_SYNC_FIRST) && (v_cnt_reg <= V_SYNC_LAST)) ? SYNC_ACTIVE_LEVEL : SYNC_IDLE;
    end

    // Raster position and running address counters, advancing one pixel per ce
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_reg    <= 11'd0;
            v_cnt_reg    <= 11'd0;
            addr_cnt_reg <= 21'd0;
        end else if (ce) begin
            h_cnt_reg    <= h_cnt_next;
            v_cnt_reg    <= v_cnt_next;
            addr_cnt_reg <= addr_cnt_next;
        end
    end

    // Stage A: framebuffer read request plus the matching timing signals
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en    <= 1'b0;
            rd_addr  <= 21'd0;
            de_a_reg <= 1'b0;
            hs_a_reg <= SYNC_IDLE;
            vs_a_reg <= SYNC_IDLE;
        end else if (ce) begin
            rd_en    <= active;
            if (active) begin
                rd_addr <= addr_cnt_reg;
            end
            de_a_reg <= active;
            hs_a_reg <= hs_now;
            vs_a_reg <= vs_now;
        end
    end

    // Stage B: timing signals wait while the framebuffer produces rd_data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_b_reg <= 1'b0;
            hs_b_reg <= SYNC_IDLE;
            vs_b_reg <= SYNC_IDLE;
        end else if (ce) begin
            de_b_reg <= de_a_reg;
            hs_b_reg <= hs_a_reg;
            vs_b_reg <= vs_a_reg;
        end
    end

    // Output stage: pixel bit gated by de so read data during blanking never leaks out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de        <= 1'b0;
            video_out <= 1'b0;
            hsync     <= SYNC_IDLE;
            vsync     <= SYNC_IDLE;
        end else if (ce) begin
            de        <= de_b_reg;
            video_out <= de_b_reg ? rd_data : 1'b0;
            hsync     <= hs_b_reg;
            vsync     <= vs_b_reg;
        end
    end

    // Scheduling hint: vertical blanking flag, not aligned with the display pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblank <= 1'b0;
        end else if (ce) begin
            vblank <= (v_cnt_reg >= V_ACTIVE);
        end
    end

    // Frame wrap pulse: evaluated every clk so it lasts one clk even with sparse ce
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= ce && frame_end;
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout with a small raster: random framebuffer contents,
// a ce-count based reference model checked every clk, and pinned literals.
module tb_fb_scanout;

    localparam int HA  = 8;
    localparam int VA  = 4;
    localparam int HFP = 1;
    localparam int HS  = 2;
    localparam int HBP = 1;
    localparam int VFP = 1;
    localparam int VS  = 1;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HS + HBP;   // 12
    localparam int VT  = VA + VFP + VS + VBP;   // 7
    localparam int F   = HT * VT;               // 84 pixel slots per frame

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        rd_en;
    logic [20:0] rd_addr;
    logic        rd_data;
    logic        hsync, vsync, de, video_out, vblank, frame_start;

    int n_checks = 0;
    int n_errors = 0;

    bit fb_mem [HA*VA];

    always #5 clk = ~clk;

    fb_scanout #(
        .HOR_ACTIVE_PIXELS(HA), .VER_ACTIVE_PIXELS(VA),
        .HOR_FRONT_PORCH(HFP), .HOR_SYNC(HS), .HOR_BACK_PORCH(HBP),
        .VER_FRONT_PORCH(VFP), .VER_SYNC(VS), .VER_BACK_PORCH(VBP),
        .SYNC_ACTIVE_LEVEL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .hsync(hsync), .vsync(vsync), .de(de), .video_out(video_out),
        .vblank(vblank), .frame_start(frame_start)
    );

    // Framebuffer read port: one ce of latency; garbage when not requested
    always @(posedge clk) begin
        if (ce) begin
            if (rd_en && rd_addr < 21'(HA*VA))
                rd_data <= fb_mem[rd_addr];
            else
                rd_data <= 1'($urandom);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: n = ce edges since reset release; slot q = n mod F
    int n;
    int m_addr;
    bit m_fs;

    function automatic bit is_active(input int q);
        return ((q % HT) < HA) && ((q / HT) < VA);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n      = 0;
            m_addr = 0;
            m_fs   = 0;
        end else begin
            m_fs = ce && (n % F == F - 1);
            if (ce) begin
                if (is_active(n % F))
                    m_addr = (n % F / HT) * HA + (n % F % HT);
                n++;
            end
        end
    end

    bit chk_on = 0;

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (chk_on) begin
            int q, x, y;
            bit e_de, e_vid, e_hs, e_vs;
            if (rst) begin
                chk("rst_rd_en", rd_en, 0);
                chk("rst_rd_addr", int'(rd_addr), 0);
                chk("rst_de", de, 0);
                chk("rst_video", video_out, 0);
                chk("rst_hsync", hsync, 1);
                chk("rst_vsync", vsync, 1);
                chk("rst_vblank", vblank, 0);
                chk("rst_frame_start", frame_start, 0);
            end else begin
                q = (n >= 1) ? (n - 1) % F : 0;
                chk("rd_en", rd_en, (n >= 1) ? int'(is_active(q)) : 0);
                chk("rd_addr", int'(rd_addr), m_addr);
                chk("vblank", vblank, (n >= 1) ? int'((q / HT) >= VA) : 0);
                chk("frame_start", frame_start, int'(m_fs));
                e_de = 0; e_vid = 0; e_hs = 1; e_vs = 1;
                if (n >= 3) begin
                    q = (n - 3) % F;
                    x = q % HT;
                    y = q / HT;
                    e_de  = is_active(q);
                    e_vid = e_de ? fb_mem[y * HA + x] : 1'b0;
                    e_hs  = !(x >= HA + HFP && x < HA + HFP + HS);
                    e_vs  = !(y >= VA + VFP && y < VA + VFP + VS);
                end
                chk("de", de, int'(e_de));
                chk("video_out", video_out, int'(e_vid));
                chk("hsync", hsync, int'(e_hs));
                chk("vsync", vsync, int'(e_vs));
            end
        end
    end

    initial begin
        int first_fs, second_fs, cyc;
        rst = 1'b1;
        ce  = 1'b0;
        foreach (fb_mem[i]) fb_mem[i] = 1'($urandom);
        fb_mem[0] = 1'b1;
        chk_on = 1;
        repeat (3) @(negedge clk);

        // Constant ce from reset release, with hand-computed expectations
        rst = 1'b0;
        ce  = 1'b1;
        for (int k = 1; k <= 86; k++) begin
            @(posedge clk);
            #1;
            case (k)
                1:  begin chk("lit_rd_en_k1", rd_en, 1); chk("lit_addr_k1", int'(rd_addr), 0); chk("lit_vblank_k1", vblank, 0); end
                2:  chk("lit_de_k2", de, 0);
                3:  begin chk("lit_de_k3", de, 1); chk("lit_video_k3", video_out, 1); end
                8:  chk("lit_addr_k8", int'(rd_addr), 7);
                9:  begin chk("lit_rd_en_k9", rd_en, 0); chk("lit_addr_hold_k9", int'(rd_addr), 7); end
                12: chk("lit_hsync_k12", hsync, 0);
                13: begin chk("lit_addr_k13", int'(rd_addr), 8); chk("lit_hsync_k13", hsync, 0); end
                14: chk("lit_hsync_k14", hsync, 1);
                44: chk("lit_addr_last", int'(rd_addr), 31);
                51: chk("lit_vblank_k51", vblank, 1);
                63: chk("lit_vsync_k63", vsync, 0);
                75: chk("lit_vsync_k75", vsync, 1);
                84: chk("lit_fs_k84", frame_start, 1);
                85: begin chk("lit_fs_k85", frame_start, 0); chk("lit_addr_k85", int'(rd_addr), 0); end
                default: ;
            endcase
        end

        // ce alternating: frame_start period must be 2*F clk
        first_fs  = -1;
        second_fs = -1;
        cyc = 0;
        while (second_fs < 0 && cyc < 1000) begin
            @(negedge clk);
            if (frame_start) begin
                if (first_fs < 0) first_fs = cyc;
                else second_fs = cyc;
            end
            ce = ~ce;
            cyc++;
        end
        chk("fs_period_found", int'(second_fs >= 0), 1);
        chk("fs_period_ce_half", second_fs - first_fs, 2 * F);

        // Random ce, then asynchronous reset in the middle of a frame
        repeat (200) begin
            @(negedge clk);
            ce = 1'($urandom);
        end
        @(negedge clk);
        ce = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async_rd_en", rd_en, 0);
        chk("async_rd_addr", int'(rd_addr), 0);
        chk("async_de", de, 0);
        chk("async_hsync", hsync, 1);
        chk("async_fs", frame_start, 0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("restart_addr", int'(rd_addr), 0);
        chk("restart_rd_en", rd_en, 1);

        // Long random-ce run against the model
        repeat (1500) begin
            @(negedge clk);
            ce = ($urandom_range(0, 3) != 0);
        end

        @(negedge clk);
        chk_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
